// File: rtl/spireg_master_pkg.sv
// Shared encodings for the SPI register-bus master: operation codes,
// command-byte prefixes, filler byte and controller state type.
package spireg_master_pkg;

  typedef enum logic [1:0] {
    OP_STATUS = 2'd0,
    OP_READ   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_FAST   = 2'd3
  } op_e;

  localparam logic [1:0] PFX_READ    = 2'b00;
  localparam logic [1:0] PFX_WRITE   = 2'b10;
  localparam logic [1:0] PFX_FAST    = 2'b11;
  localparam logic [7:0] STATUS_BYTE = 8'h00;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic logic [7:0] cmd_byte(input op_e op, input logic [5:0] addr);
    case (op)
      OP_READ:  return {PFX_READ, addr};
      OP_WRITE: return {PFX_WRITE, addr};
      OP_FAST:  return {PFX_FAST, addr};
      default:  return STATUS_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/spireg_master_shift.sv
// Mode-0 byte shifter with SCLK divider: one start pulse sends tx_byte MSB first,
// samples miso on each rising SCLK and pulses done once sclk has returned low.
module spireg_master_shift #(
  parameter int HALF_DIV = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic             active_reg;
  logic             phase_reg;
  logic [2:0]       bit_reg;
  logic [DIV_W-1:0] div_reg;
  logic [7:0]       tx_reg;
  logic [7:0]       rx_reg;
  logic             div_end;

  assign div_end = (div_reg == DIV_W'(HALF_DIV - 1));
  assign rx_byte = rx_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active_reg <= 1'b0;
      phase_reg  <= 1'b0;
      bit_reg    <= 3'd0;
      div_reg    <= '0;
      tx_reg     <= 8'h00;
      rx_reg     <= 8'h00;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active_reg <= 1'b1;
        phase_reg  <= 1'b0;
        bit_reg    <= 3'd0;
        div_reg    <= '0;
        tx_reg     <= tx_byte;
        mosi       <= tx_byte[7];
        sclk       <= 1'b0;
      end else if (active_reg) begin
        if (!div_end) begin
          div_reg <= div_reg + DIV_W'(1);
        end else begin
          div_reg <= '0;
          if (!phase_reg) begin
            sclk      <= 1'b1;
            phase_reg <= 1'b1;
            rx_reg    <= {rx_reg[6:0], miso};
          end else begin
            // mosi only moves on the falling edge, keeping mode-0 setup time
            sclk      <= 1'b0;
            phase_reg <= 1'b0;
            if (bit_reg == 3'd7) begin
              active_reg <= 1'b0;
              done       <= 1'b1;
            end else begin
              bit_reg <= bit_reg + 3'd1;
              tx_reg  <= {tx_reg[6:0], 1'b0};
              mosi    <= tx_reg[6];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/spireg_master.sv
// SPI register-bus master: sends a command byte, then streams register data
// (LSB byte first) for reads and writes, capturing the slave status byte.
module spireg_master #(
  parameter int REG_W    = 16,
  parameter int HALF_DIV = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic [REG_W-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_rdy,
  output logic [REG_W-1:0] rd_data,
  output logic             rd_vld,
  output logic [7:0]       status,
  output logic             status_vld,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  output logic             nss,
  input  logic             miso
);
  import spireg_master_pkg::*;

  localparam int         BPR       = REG_W / 8;
  localparam logic [2:0] LAST_BYTE = 3'(BPR - 1);
  localparam int         DIV_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  state_e           state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  op_e              op_reg;
  logic [5:0]       addr_reg, len_reg, reg_idx_reg;
  logic [2:0]       byte_idx_reg;
  logic             is_cmd_reg;
  logic [REG_W-1:0] wr_buf_reg, rd_acc_reg, rd_data_reg;
  logic             rd_vld_reg, status_vld_reg, busy_reg, nss_reg, cmd_ready_reg;
  logic [7:0]       status_reg;

  logic             has_data, last_byte, more, next_first, need_wdata, div_end, active_next;
  logic [2:0]       next_byte;
  logic [7:0]       wr_byte;
  logic [REG_W-1:0] rd_merged;
  logic             sh_start, sh_done;
  logic [7:0]       sh_tx, sh_rx;

  assign cmd_ready  = cmd_ready_reg;
  assign rd_data    = rd_data_reg;
  assign rd_vld     = rd_vld_reg;
  assign status     = status_reg;
  assign status_vld = status_vld_reg;
  assign busy       = busy_reg;
  assign nss        = nss_reg;

  spireg_master_shift #(.HALF_DIV(HALF_DIV)) u_shift (
    .clk     (clk),
    .nrst    (nrst),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (sh_done),
    .rx_byte (sh_rx)
  );

  // Position bookkeeping: counters name the byte just shifted; "next" is the one to start.
  always_comb begin
    has_data   = (op_reg == OP_READ) || (op_reg == OP_WRITE);
    last_byte  = (byte_idx_reg == LAST_BYTE);
    more       = is_cmd_reg ? has_data : !(last_byte && (reg_idx_reg == len_reg));
    next_first = is_cmd_reg || last_byte;
    next_byte  = next_first ? 3'd0 : byte_idx_reg + 3'd1;
    need_wdata = more && next_first && (op_reg == OP_WRITE);
    div_end    = (div_reg == DIV_W'(HALF_DIV - 1));
    wr_byte    = wr_buf_reg[7:0];
    rd_merged  = rd_acc_reg;
    for (int i = 0; i < BPR; i++) begin
      if (next_byte == 3'(i)) wr_byte = wr_buf_reg[i*8 +: 8];
      if (byte_idx_reg == 3'(i)) rd_merged[i*8 +: 8] = sh_rx;
    end
  end

  always_comb begin
    state_next = state_reg;
    sh_start   = 1'b0;
    sh_tx      = FILL_BYTE;
    wr_rdy     = 1'b0;
    case (state_reg)
      ST_IDLE:  if (cmd_valid && cmd_ready_reg) state_next = ST_SETUP;
      ST_SETUP: if (div_end) begin
        sh_start   = 1'b1;
        sh_tx      = cmd_byte(op_reg, addr_reg);
        state_next = ST_SHIFT;
      end
      ST_SHIFT: if (sh_done) state_next = ST_NEXT;
      ST_NEXT: begin
        // a stalled write keeps re-offering wr_rdy with the bus parked
        wr_rdy = need_wdata;
        if (!more) begin
          state_next = ST_HOLD;
        end else if (!need_wdata || wr_vld) begin
          sh_start   = 1'b1;
          state_next = ST_SHIFT;
          if (op_reg == OP_WRITE) sh_tx = need_wdata ? wr_data[7:0] : wr_byte;
        end
      end
      ST_HOLD:  if (div_end) state_next = ST_GAP;
      ST_GAP:   if (div_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    active_next = (state_next == ST_SETUP) || (state_next == ST_SHIFT) ||
                  (state_next == ST_NEXT)  || (state_next == ST_HOLD);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= ST_IDLE;
      div_reg        <= '0;
      op_reg         <= OP_STATUS;
      addr_reg       <= 6'd0;
      len_reg        <= 6'd0;
      reg_idx_reg    <= 6'd0;
      byte_idx_reg   <= 3'd0;
      is_cmd_reg     <= 1'b0;
      wr_buf_reg     <= '0;
      rd_acc_reg     <= '0;
      rd_data_reg    <= '0;
      rd_vld_reg     <= 1'b0;
      status_reg     <= 8'h00;
      status_vld_reg <= 1'b0;
      busy_reg       <= 1'b0;
      nss_reg        <= 1'b1;
      cmd_ready_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= (state_next != state_reg || div_end) ? '0 : div_reg + DIV_W'(1);
      cmd_ready_reg  <= (state_next == ST_IDLE);
      busy_reg       <= active_next;
      nss_reg        <= !active_next;
      rd_vld_reg     <= 1'b0;
      status_vld_reg <= 1'b0;
      if (state_reg == ST_IDLE && state_next == ST_SETUP) begin
        op_reg       <= op_e'(cmd_op);
        addr_reg     <= cmd_addr;
        len_reg      <= cmd_len;
        is_cmd_reg   <= 1'b1;
        reg_idx_reg  <= 6'd0;
        byte_idx_reg <= 3'd0;
      end
      if (state_reg == ST_SHIFT && sh_done) begin
        if (is_cmd_reg) begin
          status_reg     <= sh_rx;
          status_vld_reg <= 1'b1;
        end else if (op_reg == OP_READ) begin
          rd_acc_reg <= rd_merged;
          if (last_byte) begin
            rd_data_reg <= rd_merged;
            rd_vld_reg  <= 1'b1;
          end
        end
      end
      if (state_reg == ST_NEXT && sh_start) begin
        is_cmd_reg   <= 1'b0;
        byte_idx_reg <= next_byte;
        reg_idx_reg  <= is_cmd_reg ? 6'd0 : (last_byte ? reg_idx_reg + 6'd1 : reg_idx_reg);
        if (need_wdata) wr_buf_reg <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_spireg_master.sv
// Randomised scoreboard bench for spireg_master with a behavioural SPI register slave.
module tb_spireg_master;
  localparam int REG_W    = 16;
  localparam int HALF_DIV = 2;
  localparam int BPR      = REG_W / 8;

  logic             clk = 1'b0, nrst = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [5:0]       cmd_addr = '0, cmd_len = '0;
  logic [REG_W-1:0] wr_data = '0, rd_data;
  logic             wr_vld = 1'b0, wr_rdy, rd_vld;
  logic [7:0]       status;
  logic             status_vld, busy, sclk, mosi, nss;
  logic             miso = 1'b0;

  spireg_master #(.REG_W(REG_W), .HALF_DIV(HALF_DIV)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .rd_data(rd_data), .rd_vld(rd_vld), .status(status), .status_vld(status_vld),
    .busy(busy), .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int stat_pulses = 0, rd_pulses = 0;

  logic [REG_W-1:0] slv_regs  [64];
  logic [REG_W-1:0] mdl_regs  [64];
  logic [REG_W-1:0] wdata_buf [64];
  logic [7:0]       exp_mosi_q[$];
  logic [7:0]       exp_status_q[$];
  logic [REG_W-1:0] exp_rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h", name, act);
  endtask

  // SPI slave: first MISO byte is reg0 low byte, reads stream regs LSB byte first,
  // writes store, fast code 5 sets reg0 bit 2 and code 6 clears it.
  int         sl_bit = 0, sl_cnt = 0;
  logic [7:0] sl_in = '0, sl_out = '0, sl_next = '0, sl_cmd = '0;
  logic       nss_q = 1'b1, sclk_q = 1'b0;

  function automatic logic [7:0] slv_byte(input int idx, input int b);
    if (idx > 63) return 8'h00;
    return 8'(slv_regs[idx] >> (8 * b));
  endfunction

  task automatic slave_byte();
    int d, a;
    if (exp_mosi_q.size() == 0) unexpected("mosi_extra", sl_in);
    else check("mosi_byte", sl_in, exp_mosi_q.pop_front());
    if (sl_cnt == 0) begin
      sl_cmd = sl_in;
      if (sl_in[7:6] == 2'b11 && sl_in[5:0] == 6'd5) slv_regs[0][2] = 1'b1;
      if (sl_in[7:6] == 2'b11 && sl_in[5:0] == 6'd6) slv_regs[0][2] = 1'b0;
    end else if (sl_cmd[7:6] == 2'b10) begin
      d = sl_cnt - 1;
      a = int'(sl_cmd[5:0]) + d / BPR;
      if (a < 64) slv_regs[a][(d % BPR)*8 +: 8] = sl_in;
    end
    sl_next = (sl_cmd[7:6] == 2'b00) ? slv_byte(int'(sl_cmd[5:0]) + sl_cnt / BPR, sl_cnt % BPR) : 8'h00;
  endtask

  always @(nss or sclk) begin
    if (nss_q === 1'b1 && nss === 1'b0) begin
      sl_bit = 0;
      sl_cnt = 0;
      sl_out = slv_regs[0][7:0];
      miso   = sl_out[7];
    end else if (nss === 1'b0 && sclk_q === 1'b0 && sclk === 1'b1) begin
      sl_in = {sl_in[6:0], mosi};
      sl_bit++;
      if (sl_bit == 8) begin
        slave_byte();
        sl_bit = 0;
        sl_cnt++;
      end
    end else if (nss === 1'b0 && sclk_q === 1'b1 && sclk === 1'b0) begin
      if (sl_bit == 0) sl_out = sl_next;
      miso = sl_out[7 - sl_bit];
    end
    nss_q  = nss;
    sclk_q = sclk;
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (nrst) begin
      if (status_vld) begin
        stat_pulses++;
        if (exp_status_q.size() == 0) unexpected("status_extra", status);
        else check("status", status, exp_status_q.pop_front());
      end
      if (rd_vld) begin
        rd_pulses++;
        if (exp_rd_q.size() == 0) unexpected("rd_extra", rd_data);
        else check("rd_data", rd_data, exp_rd_q.pop_front());
      end
    end
  end

  // Reference model: expected bus bytes and results from the command semantics.
  task automatic model_push(input int op, input int addr, input int len);
    logic [7:0] cb;
    exp_status_q.push_back(mdl_regs[0][7:0]);
    case (op)
      0:       cb = 8'h00;
      1:       cb = 8'(addr);
      2:       cb = 8'h80 + 8'(addr);
      default: cb = 8'hC0 + 8'(addr);
    endcase
    exp_mosi_q.push_back(cb);
    if (op == 1) begin
      for (int i = 0; i <= len; i++) begin
        for (int b = 0; b < BPR; b++) exp_mosi_q.push_back(8'hFF);
        exp_rd_q.push_back(mdl_regs[addr + i]);
      end
    end else if (op == 2) begin
      for (int i = 0; i <= len; i++) begin
        for (int b = 0; b < BPR; b++) exp_mosi_q.push_back(8'(wdata_buf[i] >> (8 * b)));
        mdl_regs[addr + i] = wdata_buf[i];
      end
    end else if (op == 3) begin
      if (addr == 5) mdl_regs[0][2] = 1'b1;
      if (addr == 6) mdl_regs[0][2] = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) unexpected({name, "_ready_timeout"}, t);
  endtask

  task automatic issue_cmd(input int op, input int addr, input int len);
    @(negedge clk);
    wait_ready("issue");
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_addr  = 6'(addr);
    cmd_len   = 6'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 6'($urandom);
    cmd_len   = 6'($urandom);
  endtask

  task automatic run_cmd(input int op, input int addr, input int len,
                         input int stall_reg, input int stall_cycles);
    int accepts = 0;
    int t;
    logic stall_bad;
    stat_pulses = 0;
    rd_pulses   = 0;
    model_push(op, addr, len);
    issue_cmd(op, addr, len);
    if (op == 2) begin
      for (int i = 0; i <= len; i++) begin
        if (i == stall_reg) begin
          wr_vld = 1'b0;
          t = 0;
          while (wr_rdy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
          stall_bad = 1'b0;
          repeat (stall_cycles) begin
            @(negedge clk);
            if (sclk !== 1'b0 || nss !== 1'b0 || wr_rdy !== 1'b1) stall_bad = 1'b1;
          end
          check("stall_bus_parked", stall_bad, 1'b0);
        end
        wr_data = wdata_buf[i];
        wr_vld  = 1'b1;
        t = 0;
        while (wr_rdy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (t < 2000) accepts++;
        @(posedge clk);
        #1;
        wr_vld  = 1'b0;
        wr_data = REG_W'($urandom);
      end
      check("wr_accepts", accepts, len + 1);
    end
    wait_ready("done");
    check("status_pulses", stat_pulses, 1);
    check("rd_pulses", rd_pulses, (op == 1) ? len + 1 : 0);
    check("mosi_left", exp_mosi_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    $display("txn op=%0d addr=%0d len=%0d status=%02h rd_pulses=%0d", op, addr, len, status, rd_pulses);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, addr, len, st_reg, st_cyc, t;
    for (int i = 0; i < 64; i++) begin
      slv_regs[i] = REG_W'($urandom);
      mdl_regs[i] = slv_regs[i];
    end
    slv_regs[0] = 16'h005A;
    mdl_regs[0] = 16'h005A;

    repeat (2) @(negedge clk);
    check("rst_nss", nss, 1'b1);
    check("rst_sclk_mosi", {sclk, mosi}, 2'b00);
    check("rst_ctrl", {busy, cmd_ready, wr_rdy, rd_vld, status_vld}, 5'b0);
    check("rst_data", {rd_data, status}, '0);
    nrst = 1'b1;
    #1 check("ready_before_clk", cmd_ready, 1'b0);
    @(negedge clk);
    check("ready_after_clk", cmd_ready, 1'b1);

    run_cmd(0, 0, 0, -1, 0);
    wdata_buf[0] = 16'h1234;
    wdata_buf[1] = 16'hABCD;
    run_cmd(2, 3, 1, -1, 0);
    run_cmd(1, 3, 1, -1, 0);
    wdata_buf[0] = 16'h00C3;
    run_cmd(2, 0, 0, -1, 0);
    run_cmd(1, 0, 0, -1, 0);
    run_cmd(3, 5, 0, -1, 0);
    run_cmd(0, 0, 0, -1, 0);
    check("fast_bit2", mdl_regs[0][2], 1'b1);
    for (int i = 0; i < 3; i++) wdata_buf[i] = REG_W'($urandom);
    run_cmd(2, 10, 2, 1, 20);
    run_cmd(1, 10, 2, -1, 0);

    // abort a read in the middle of byte 2
    stat_pulses = 0;
    rd_pulses   = 0;
    model_push(1, 0, 1);
    issue_cmd(1, 0, 1);
    t = 0;
    while (!(sl_cnt == 2 && sl_bit == 3) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) unexpected("abort_wait_timeout", t);
    nrst = 1'b0;
    #1;
    check("abort_nss_sclk", {nss, sclk}, 2'b10);
    check("abort_busy", busy, 1'b0);
    exp_mosi_q.delete();
    exp_rd_q.delete();
    exp_status_q.delete();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    check("abort_rd_pulses", rd_pulses, 0);
    run_cmd(0, 0, 0, -1, 0);

    for (int k = 0; k < 25; k++) begin
      op     = $urandom_range(0, 3);
      len    = $urandom_range(0, 3);
      addr   = $urandom_range(0, 63 - len);
      st_reg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      st_cyc = $urandom_range(1, 10);
      if (op == 3) addr = $urandom_range(4, 7);
      for (int i = 0; i <= len; i++) wdata_buf[i] = REG_W'($urandom);
      run_cmd(op, addr, len, st_reg, st_cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
